agc_cdu_link: RTL

AGC_CDU_LINK -- requirements
Module: agc_cdu_link

---
 rtl/agc_cdu_link_pkg.sv | 26 ++
 rtl/agc_cdu_link_err_pulse_gen.sv | 83 ++++++++
 rtl/agc_cdu_link.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/agc_cdu_link_pkg.sv
// -----------------------------------------------------------------------------
// agc_cdu_pkg
// Shared types and widths for the AGC <-> CDU link block:
//   cmd_op_e  : command opcodes carried on cmd_op
//   zstate_e  : state of the AGCZ (zero) pulse sequencer
//   ANGLE_W   : width of the CDU angle counter
//   ERRCNT_W  : width of the signed error-burst pulse count
// -----------------------------------------------------------------------------
package agc_cdu_pkg;

    localparam int ANGLE_W  = 15;
    localparam int ERRCNT_W = 9;

    typedef enum logic [1:0] {
        CMD_ZERO    = 2'd0,
        CMD_CA_ON   = 2'd1,
        CMD_CA_OFF  = 2'd2,
        CMD_EEC_SET = 2'd3
    } cmd_op_e;

    typedef enum logic {
        Z_IDLE  = 1'b0,
        Z_PULSE = 1'b1
    } zstate_e;

endpackage

// File: rtl/agc_cdu_link_err_pulse_gen.sv
// -----------------------------------------------------------------------------
// err_pulse_gen
// Converts one signed error burst into |count| single-cycle pulses on errp
// (positive count) or errm (negative count). The first pulse is issued the
// cycle after start; later pulses follow every PULSE_DIV cycles.
//
// Ports:
//   clk       in   clock (CLOCKH)
//   rst       in   asynchronous active-high reset
//   start     in   accepted burst (err_valid && err_ready) this cycle
//   count     in   signed pulse count for the burst
//   eec_next  in   value AGCEEC takes on the next edge; low aborts the burst
//   errp/errm out  error-counter drive pulses
//   busy      out  burst in progress
// -----------------------------------------------------------------------------
module err_pulse_gen
    import agc_cdu_pkg::*;
#(
    parameter int PULSE_DIV = 320
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [ERRCNT_W-1:0] count,
    input  logic                       eec_next,
    output logic                       errp,
    output logic                       errm,
    output logic                       busy
);

    localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(PULSE_DIV - 1);

    logic [ERRCNT_W-1:0] magnitude;
    logic [ERRCNT_W-1:0] remaining;
    logic [DIV_W-1:0]    div_cnt;
    logic                neg;

    // Unsigned magnitude: -256 maps to 9'h100, which still fits in 9 bits.
    always_comb begin
        magnitude = count[ERRCNT_W-1] ? (~count + 1'b1) : count;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errp      <= 1'b0;
            errm      <= 1'b0;
            busy      <= 1'b0;
            neg       <= 1'b0;
            remaining <= '0;
            div_cnt   <= '0;
        end else begin
            errp <= 1'b0;
            errm <= 1'b0;
            if (busy) begin
                // remaining==0 here means the last pulse is on the wire now,
                // so busy drops after this cycle; an EEC drop aborts at once.
                if (!eec_next || remaining == '0) begin
                    busy      <= 1'b0;
                    remaining <= '0;
                    div_cnt   <= '0;
                end else if (div_cnt == '0) begin
                    errp      <= ~neg;
                    errm      <= neg;
                    remaining <= remaining - 1'b1;
                    div_cnt   <= DIV_RELOAD;
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end else if (start && eec_next && count != '0) begin
                busy      <= 1'b1;
                neg       <= count[ERRCNT_W-1];
                errp      <= ~count[ERRCNT_W-1];
                errm      <= count[ERRCNT_W-1];
                remaining <= magnitude - 1'b1;
                div_cnt   <= DIV_RELOAD;
            end
        end
    end

endmodule

// File: rtl/agc_cdu_link.sv
// -----------------------------------------------------------------------------
// agc_cdu_link
// AGC side of the CDU interface: tracks the CDU angle from CDUP/CDUM pulses,
// executes ZERO / CA_ON / CA_OFF / EEC_SET commands, and drives signed error
// bursts to the CDU error counter as ERRP/ERRM pulse trains.
//
// Ports:
//   CLOCKH                in   sole clock
//   rst                   in   asynchronous active-high reset
//   CDUP, CDUM            in   angle increment / decrement pulses
//   cmd_valid/cmd_ready   in/out command handshake
//   cmd_op [1:0]          in   ZERO=0, CA_ON=1, CA_OFF=2, EEC_SET=3
//   cmd_eec               in   new AGCEEC level for EEC_SET
//   err_valid/err_ready   in/out error-burst handshake
//   err_count [8:0]       in   signed pulse count
//   AGCZ, AGCCA, AGCEEC   out  commands to the CDU
//   ERRP, ERRM            out  error-counter drive pulses
//   angle [14:0]          out  CDU angle counter
//   err_busy              out  burst in progress
//   angle_ovf             out  sticky wrap flag (only with AGC_CDU_OVF_EN)
//
// Build option: define AGC_CDU_OVF_EN to add the angle_ovf output.
// -----------------------------------------------------------------------------
module agc_cdu_link
    import agc_cdu_pkg::*;
#(
    parameter int PULSE_DIV  = 320,
    parameter int ZPULSE_LEN = 4
) (
    input  logic                CLOCKH,
    input  logic                rst,
    input  logic                CDUP,
    input  logic                CDUM,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic                cmd_eec,
    input  logic                err_valid,
    output logic                err_ready,
    input  logic [ERRCNT_W-1:0] err_count,
    output logic                AGCZ,
    output logic                AGCCA,
    output logic                AGCEEC,
    output logic                ERRP,
    output logic                ERRM,
    output logic [ANGLE_W-1:0]  angle,
    output logic                err_busy
`ifdef AGC_CDU_OVF_EN
    ,
    output logic                angle_ovf
`endif
);

    localparam logic [ANGLE_W-1:0] ANGLE_MAX = {ANGLE_W{1'b1}};

    zstate_e            state_q, state_d;
    logic [3:0]         zcnt_q, zcnt_d;
    logic               started_q;
    logic               cmd_fire;
    logic               zero_fire;
    logic               eec_next;
    logic [ANGLE_W-1:0] angle_d;
    cmd_op_e            op;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign zero_fire = cmd_fire && (op == CMD_ZERO);
    assign eec_next  = (cmd_fire && op == CMD_EEC_SET) ? cmd_eec : AGCEEC;

    assign AGCZ      = (state_q == Z_PULSE);
    // started_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = started_q && (state_q == Z_IDLE);
    assign err_ready = AGCEEC && !err_busy;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        case (state_q)
            Z_IDLE: begin
                if (zero_fire) begin
                    state_d = Z_PULSE;
                    zcnt_d  = 4'(ZPULSE_LEN - 1);
                end
            end
            Z_PULSE: begin
                if (zcnt_q == '0) begin
                    state_d = Z_IDLE;
                end else begin
                    zcnt_d = zcnt_q - 1'b1;
                end
            end
            default: state_d = Z_IDLE;
        endcase
    end

    // ZERO and the AGCZ pulse both pin the angle at 0, masking CDUP/CDUM.
    always_comb begin
        angle_d = angle;
        if (zero_fire || AGCZ) begin
            angle_d = '0;
        end else if (CDUP && !CDUM) begin
            angle_d = angle + 1'b1;
        end else if (CDUM && !CDUP) begin
            angle_d = angle - 1'b1;
        end
    end

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            state_q   <= Z_IDLE;
            zcnt_q    <= '0;
            started_q <= 1'b0;
            angle     <= '0;
            AGCCA     <= 1'b0;
            AGCEEC    <= 1'b0;
        end else begin
            state_q   <= state_d;
            zcnt_q    <= zcnt_d;
            started_q <= 1'b1;
            angle     <= angle_d;
            AGCEEC    <= eec_next;
            if (cmd_fire && op == CMD_CA_ON) begin
                AGCCA <= 1'b1;
            end else if (cmd_fire && op == CMD_CA_OFF) begin
                AGCCA <= 1'b0;
            end
        end
    end

`ifdef AGC_CDU_OVF_EN
    logic ovf_hit;

    assign ovf_hit = !zero_fire && !AGCZ &&
                     ((CDUP && !CDUM && angle == ANGLE_MAX) ||
                      (CDUM && !CDUP && angle == '0));

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            angle_ovf <= 1'b0;
        end else if (zero_fire) begin
            angle_ovf <= 1'b0;
        end else if (ovf_hit) begin
            angle_ovf <= 1'b1;
        end
    end
`endif

    err_pulse_gen #(
        .PULSE_DIV (PULSE_DIV)
    ) u_err_pulse_gen (
        .clk      (CLOCKH),
        .rst      (rst),
        .start    (err_valid && err_ready),
        .count    (err_count),
        .eec_next (eec_next),
        .errp     (ERRP),
        .errm     (ERRM),
        .busy     (err_busy)
    );

endmodule
